// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - 640x480@60 timing constants, coordinate type and decode helper
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_SYNC_POL = 0;
    localparam int DEF_CLK_DIV  = 4;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_HS_FIRST = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_LAST  = DEF_HS_FIRST + DEF_H_SYNC - 1;
    localparam int DEF_VS_FIRST = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_LAST  = DEF_VS_FIRST + DEF_V_SYNC - 1;

    function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle shared by the generator and the layer stages
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic   pix_tick;
    coord_t x_pos;
    coord_t y_pos;
    logic   active;
    logic   hsync;
    logic   vsync;
    logic   line_start;
    logic   frame_start;

    modport master (
        output pix_tick, x_pos, y_pos, active, hsync, vsync, line_start, frame_start
    );
    modport slave (
        input  pix_tick, x_pos, y_pos, active, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen_pix_clk_en.sv
// rtl/vga_timing_gen_pix_clk_en.sv - CLK_DIV enable divider producing a registered one-clk tick
module pix_clk_en #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_q;

    always_comb begin
        div_cnt_d = (div_cnt_q == CNT_LAST) ? '0 : div_cnt_q + 1'b1;
    end

    // Registered so the tick is 0 in the reset state even when CLK_DIV is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= (div_cnt_d == CNT_LAST);
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel-rate h/v raster counters with registered sync/active/strobe decode
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = DEF_SYNC_POL,
    parameter int CLK_DIV  = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  vga_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the coordinate width");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
    endgenerate

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
    localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic   SYNC_ON  = (SYNC_POL != 0);

    logic   pix_tick;
    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;
    logic   active_q, active_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   line_start_q, line_start_d;
    logic   frame_start_q, frame_start_d;

    pix_clk_en #(.CLK_DIV(CLK_DIV)) u_pix_clk_en (
        .clk  (clk),
        .rst  (rst),
        .tick (pix_tick)
    );

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + coord_t'(1);
            end else begin
                h_cnt_d = h_cnt_q + coord_t'(1);
            end
        end
    end

    // Decode from the next counter values so every output lands on the same edge as x/y.
    always_comb begin
        active_d      = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
        hsync_d       = in_range(h_cnt_d, HS_FIRST, HS_LAST) ? SYNC_ON : !SYNC_ON;
        vsync_d       = in_range(v_cnt_d, VS_FIRST, VS_LAST) ? SYNC_ON : !SYNC_ON;
        line_start_d  = pix_tick && (h_cnt_d == '0);
        frame_start_d = line_start_d && (v_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= H_LAST;
            v_cnt_q       <= V_LAST;
            active_q      <= 1'b0;
            hsync_q       <= !SYNC_ON;
            vsync_q       <= !SYNC_ON;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_o.pix_tick    = pix_tick;
    assign vga_o.x_pos       = h_cnt_q;
    assign vga_o.y_pos       = v_cnt_q;
    assign vga_o.active      = active_q;
    assign vga_o.hsync       = hsync_q;
    assign vga_o.vsync       = vsync_q;
    assign vga_o.line_start  = line_start_q;
    assign vga_o.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen across three timing configurations
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic clk;
    logic rst;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();
    vga_timing_gen_if if_c ();

    vga_timing_gen u_dut_a (.clk(clk), .rst(rst), .vga_o(if_a));

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(0),  .CLK_DIV(3)
    ) u_dut_b (.clk(clk), .rst(rst), .vga_o(if_b));

    vga_timing_gen #(.SYNC_POL(1), .CLK_DIV(1)) u_dut_c (.clk(clk), .rst(rst), .vga_o(if_c));

    int c_ha [3] = '{640, 16, 640};
    int c_hfp[3] = '{16,  2,  16};
    int c_hs [3] = '{96,  3,  96};
    int c_hbp[3] = '{48,  3,  48};
    int c_va [3] = '{480, 6,  480};
    int c_vfp[3] = '{10,  1,  10};
    int c_vs [3] = '{2,   2,  2};
    int c_vbp[3] = '{33,  2,  33};
    int c_cd [3] = '{4,   3,  1};
    int c_pol[3] = '{0,   0,  1};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference raster model, one state per DUT.
    int m_div[3], m_x[3], m_y[3];
    bit m_tick[3], m_ls[3], m_fs[3];
    bit sb_en = 1'b0;
    bit adv;

    typedef struct {
        int          id;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    function automatic logic [31:0] model_pack(int i);
        logic pol, act, hs_on, vs_on;
        pol   = (c_pol[i] != 0);
        act   = (m_x[i] < c_ha[i]) && (m_y[i] < c_va[i]);
        hs_on = (m_x[i] >= c_ha[i] + c_hfp[i]) && (m_x[i] < c_ha[i] + c_hfp[i] + c_hs[i]);
        vs_on = (m_y[i] >= c_va[i] + c_vfp[i]) && (m_y[i] < c_va[i] + c_vfp[i] + c_vs[i]);
        return {6'b0, m_tick[i], 10'(m_x[i]), 10'(m_y[i]), act,
                hs_on ? pol : !pol, vs_on ? pol : !pol, m_ls[i], m_fs[i]};
    endfunction

    function automatic logic [31:0] obs_pack(int i);
        case (i)
            0: return {6'b0, if_a.pix_tick, if_a.x_pos, if_a.y_pos, if_a.active,
                       if_a.hsync, if_a.vsync, if_a.line_start, if_a.frame_start};
            1: return {6'b0, if_b.pix_tick, if_b.x_pos, if_b.y_pos, if_b.active,
                       if_b.hsync, if_b.vsync, if_b.line_start, if_b.frame_start};
            default: return {6'b0, if_c.pix_tick, if_c.x_pos, if_c.y_pos, if_c.active,
                       if_c.hsync, if_c.vsync, if_c.line_start, if_c.frame_start};
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) sb_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_div[i]  = 0;
                m_x[i]    = c_ha[i] + c_hfp[i] + c_hs[i] + c_hbp[i] - 1;
                m_y[i]    = c_va[i] + c_vfp[i] + c_vs[i] + c_vbp[i] - 1;
                m_tick[i] = 1'b0;
                m_ls[i]   = 1'b0;
                m_fs[i]   = 1'b0;
            end else begin
                adv       = m_tick[i];
                m_div[i]  = (m_div[i] + 1) % c_cd[i];
                m_tick[i] = (m_div[i] == c_cd[i] - 1);
                m_ls[i]   = 1'b0;
                m_fs[i]   = 1'b0;
                if (adv) begin
                    m_x[i]++;
                    if (m_x[i] == c_ha[i] + c_hfp[i] + c_hs[i] + c_hbp[i]) begin
                        m_x[i] = 0;
                        m_y[i]++;
                        if (m_y[i] == c_va[i] + c_vfp[i] + c_vs[i] + c_vbp[i]) m_y[i] = 0;
                    end
                    m_ls[i] = (m_x[i] == 0);
                    m_fs[i] = m_ls[i] && (m_y[i] == 0);
                end
            end
            if (sb_en) sb_q.push_back('{id: i, exp: model_pack(i)});
        end
    end

    always @(negedge clk) begin
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq($sformatf("sb_dut%0d", e.id), obs_pack(e.id), e.exp);
        end
    end

    int n, t, ls_t, fall_x, hs_ticks, c_hs_cyc, b_fs1, b_fs2, b_vs_ticks;
    bit act_fell, found;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_x",  if_a.x_pos, 799);
        check_eq("rst_y",  if_a.y_pos, 524);
        check_eq("rst_act", if_a.active, 0);
        check_eq("rst_hs", if_a.hsync, 1);
        check_eq("rst_vs", if_a.vsync, 1);
        check_eq("rst_tick", if_a.pix_tick, 0);
        check_eq("rst_strobes", {if_a.line_start, if_a.frame_start}, 0);
        check_eq("rst_hs_pol1", if_c.hsync, 0);
        check_eq("rst_tick_div1", if_c.pix_tick, 0);

        rst = 1'b0;
        n = 0;
        while (!if_a.frame_start && n < 20) begin @(negedge clk); n++; end
        check_eq("first_fs_lat", n, 4);
        check_eq("first_xy", {if_a.x_pos, if_a.y_pos}, 0);
        check_eq("first_ls_act", {if_a.line_start, if_a.active}, 2'b11);
        @(negedge clk);
        check_eq("strobe_width", {if_a.line_start, if_a.frame_start}, 0);
        check_eq("div1_tick_high", if_c.pix_tick, 1);

        // One full line of the default DUT; the small DUT runs whole frames meanwhile.
        t = 1; ls_t = 0; fall_x = -1; hs_ticks = 0; c_hs_cyc = 0;
        b_fs1 = -1; b_fs2 = -1; b_vs_ticks = 0; act_fell = 1'b0;
        while (ls_t == 0 && t < 3400) begin
            if (!act_fell && !if_a.active) begin act_fell = 1'b1; fall_x = if_a.x_pos; end
            if (if_a.pix_tick && !if_a.hsync) hs_ticks++;
            if (if_c.y_pos == 0 && if_c.hsync) c_hs_cyc++;
            if (if_b.frame_start) begin
                if (b_fs1 < 0) b_fs1 = t;
                else if (b_fs2 < 0) b_fs2 = t;
            end
            if (b_fs1 >= 0 && b_fs2 < 0 && if_b.pix_tick && !if_b.vsync) b_vs_ticks++;
            @(negedge clk);
            t++;
            if (if_a.line_start) ls_t = t;
        end
        check_eq("line_period_clks", ls_t, 3200);
        check_eq("active_fall_x", fall_x, 640);
        check_eq("hsync_low_ticks", hs_ticks, 96);
        check_eq("div1_hsync_high_cyc", c_hs_cyc, 96);
        check_eq("small_frame_period", b_fs2 - b_fs1, 792);
        check_eq("small_vsync_ticks", b_vs_ticks, 48);
        check_eq("line1_y", if_a.y_pos, 1);

        // Reset coincident with a tick, mid-line.
        found = 1'b0;
        n = 0;
        while (!found && n < 2000) begin
            @(negedge clk); n++;
            if (if_a.pix_tick && if_a.x_pos == 300) found = 1'b1;
        end
        check_eq("wait_x300", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_xy", {if_a.x_pos, if_a.y_pos}, {10'd799, 10'd524});
        check_eq("midrst_sync_act", {if_a.hsync, if_a.vsync, if_a.active}, 3'b110);
        rst = 1'b0;
        n = 0;
        while (!if_a.frame_start && n < 20) begin @(negedge clk); n++; end
        check_eq("restart_fs_lat", n, 4);
        check_eq("restart_xy", {if_a.x_pos, if_a.y_pos}, 0);

        repeat (1500) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
